// File: rtl/stack_mem_pkg.sv
// stack_mem_pkg: shared types and helpers for the stack CPU memory controller.
//   state_t      : controller FSM states (zero-fill sweep, serving requests)
//   RD_LAT_LIST  : legal read latencies, lowest first
//   par_even()   : even parity of a word (XOR of all bits)
// Optional feature macro: STACK_MEM_PARITY_EN (per-word parity bit in the array).
package stack_mem_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   // Legal RD_LAT values: entry 0 = 1 cycle, entry 1 = 2 cycles.
   localparam logic [1:0][1:0] RD_LAT_LIST = {2'd2, 2'd1};

   // Callers zero-extend narrower words; zero bits do not change the XOR.
   function automatic logic par_even(input logic [63:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/stack_mem_array.sv
// stack_mem_array: single-port storage with one write port and one registered
// read port sharing the address.
//   clk, rst_n : clock, async active-low reset (read register only)
//   addr       : word address for both read and write
//   we / wdata / wpar : write enable, data and parity bit to store
//   re         : load the read register from addr this cycle
//   rdata/rpar : registered read data and stored parity bit
// With STACK_MEM_PARITY_EN the array is DATA_W+1 bits wide; otherwise the
// parity bit is not stored and rpar reads as 0.
module stack_mem_array
   import stack_mem_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic              re,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wpar,
   output logic [DATA_W-1:0] rdata,
   output logic              rpar
);

   localparam int DEPTH = 2 ** ADDR_W;

`ifdef STACK_MEM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
   logic [MEM_W-1:0] wr_word;
   assign wr_word = {wpar, wdata};
`else
   localparam int MEM_W = DATA_W;
   logic [MEM_W-1:0] wr_word;
   logic             unused_wpar;
   assign wr_word     = wdata;
   assign unused_wpar = wpar;
`endif

   logic [MEM_W-1:0] mem_q [DEPTH];
   logic [MEM_W-1:0] rd_q, rd_d;

   // Storage itself has no reset; the post-reset sweep clears it.
   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wr_word;
   end

   // Read register only loads on a read so the response holds between reads.
   always_comb begin
      rd_d = rd_q;
      if (re) rd_d = mem_q[addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= rd_d;
   end

   assign rdata = rd_q[DATA_W-1:0];
`ifdef STACK_MEM_PARITY_EN
   assign rpar = rd_q[DATA_W];
`else
   assign rpar = 1'b0;
`endif

endmodule

// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl: parametrised single-port memory for the stack CPU with a
// valid/ready request port, pipelined in-order read responses and a zero-fill
// sweep of the whole array after every reset.
//   req_valid/req_ready : request handshake (ready only after the sweep)
//   req_write/addr/wdata: request fields; inj_perr stores inverted parity
//   rsp_valid/rdata/perr: read response, RD_LAT cycles after acceptance
//   init_done           : sweep finished (same as req_ready)
// Optional feature macro: STACK_MEM_PARITY_EN (parity store/check; without it
// rsp_perr is 0 and inj_perr is ignored).
module stack_mem_ctrl
   import stack_mem_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              inj_perr,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_perr,
   output logic              init_done
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                rd_vld_q, rd_vld_d;

   logic                arr_we, arr_re, arr_wpar, arr_rpar;
   logic [ADDR_W-1:0]   arr_addr;
   logic [DATA_W-1:0]   arr_wdata, arr_rdata;
   logic                req_wpar, stg1_perr;

`ifdef STACK_MEM_PARITY_EN
   assign req_wpar  = par_even(64'(req_wdata)) ^ inj_perr;
   assign stg1_perr = par_even(64'(arr_rdata)) ^ arr_rpar;
`else
   logic unused_par;
   assign unused_par = inj_perr ^ arr_rpar;
   assign req_wpar   = 1'b0;
   assign stg1_perr  = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      arr_we    = 1'b0;
      arr_re    = 1'b0;
      arr_addr  = req_addr;
      arr_wdata = req_wdata;
      arr_wpar  = req_wpar;
      case (state_q)
         ST_INIT: begin
            // Zero word with its (zero) even parity, one address per cycle.
            arr_we    = 1'b1;
            arr_addr  = cnt_q;
            arr_wdata = '0;
            arr_wpar  = 1'b0;
            cnt_d     = cnt_q + 1'b1;
            if (&cnt_q) state_d = ST_READY;
         end
         ST_READY: begin
            arr_we = req_valid &&  req_write;
            arr_re = req_valid && !req_write;
         end
         default: state_d = ST_INIT;
      endcase
      rd_vld_d = arr_re;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_INIT;
         cnt_q    <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   assign req_ready = (state_q == ST_READY);
   assign init_done = req_ready;

   stack_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (arr_addr),
      .we    (arr_we),
      .re    (arr_re),
      .wdata (arr_wdata),
      .wpar  (arr_wpar),
      .rdata (arr_rdata),
      .rpar  (arr_rpar)
   );

   // Latency 2 adds one register stage that moves valid, data and parity
   // error together; any other value builds the single-stage path.
   if (RD_LAT == int'(RD_LAT_LIST[1])) begin : g_lat2
      logic              vld2_q, vld2_d, perr2_q, perr2_d;
      logic [DATA_W-1:0] rdata2_q, rdata2_d;

      always_comb begin
         vld2_d   = rd_vld_q;
         rdata2_d = rdata2_q;
         perr2_d  = perr2_q;
         if (rd_vld_q) begin
            rdata2_d = arr_rdata;
            perr2_d  = stg1_perr;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld2_q   <= 1'b0;
            rdata2_q <= '0;
            perr2_q  <= 1'b0;
         end else begin
            vld2_q   <= vld2_d;
            rdata2_q <= rdata2_d;
            perr2_q  <= perr2_d;
         end
      end

      assign rsp_valid = vld2_q;
      assign rsp_rdata = rdata2_q;
      assign rsp_perr  = perr2_q;
   end else begin : g_lat1
      assign rsp_valid = rd_vld_q;
      assign rsp_rdata = arr_rdata;
      assign rsp_perr  = stg1_perr;
   end

endmodule
